seq_det_scheduler: RTL

Round-robin scheduler that shares one serial sequence detector among `N_REQ` requesters. It grants one requester at a time and captures that requester's `WIDTH`-bit word. It clears the detector, streams the word into it LSB-first, one bit per clock, then returns the number of detections with the winner's ID. It sits between the requester-side logic and a single non-overlapping sequence detector instance.

---
 rtl/seq_det_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin front end that shares one serial sequence
// detector among 2**ID_W requesters. The scheduler grants one requester and
// captures its word. It clears the detector and streams the word LSB-first.
// It then reports how many detections that word produced.
module seq_det_scheduler #(
  parameter int ID_W  = 2,
  parameter int WIDTH = 14,
  parameter int CNT_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(2**ID_W)-1:0]          req,
  input  logic [(2**ID_W)*WIDTH-1:0]    data_in,
  output logic [(2**ID_W)-1:0]          grant,
  output logic                          busy,
  output logic                          done,
  output logic [ID_W-1:0]               result_id,
  output logic [CNT_W-1:0]              result_count,
  output logic                          det_clr,
  output logic                          det_bit,
  output logic                          det_valid,
  input  logic                          det_detected
);

  localparam int N_REQ = 2**ID_W;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t              state_reg;
  logic [ID_W-1:0]     rr_reg;
  logic [ID_W-1:0]     id_reg;
  logic [WIDTH-1:0]    shift_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    bit_idx_reg;

  logic [WIDTH-1:0]    word_arr [N_REQ];
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;
  logic                count_en;
  logic [CNT_W-1:0]    cnt_next;

  // Split the flat data bus into per-requester words and decode the grant.
  // The grant is shown only in CLEAR and is masked while reset is held.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign word_arr[gi] = data_in[gi*WIDTH +: WIDTH];
      assign grant[gi]    = !rst && (state_reg == CLEAR) && (id_reg == ID_W'(gi));
    end
  endgenerate

  // Round-robin search: first asserted request starting at rr_reg, wrapping.
  // The wrap is free because N_REQ is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = rr_reg + ID_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Detection counting window covers STREAM after its first cycle, plus DRAIN.
  // Pulses in CLEAR and the first STREAM cycle are leftovers and are ignored.
  always_comb begin
    count_en = det_detected &&
               (((state_reg == STREAM) && (bit_idx_reg != '0)) || (state_reg == DRAIN));
    cnt_next = cnt_reg;
    if (count_en && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Control FSM: arbitrate, clear, stream the word, drain, then report the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_reg       <= '0;
      id_reg       <= '0;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      result_id    <= '0;
      result_count <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            rr_reg    <= win_id + ID_W'(1);
            id_reg    <= win_id;
            shift_reg <= word_arr[win_id];
            state_reg <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          state_reg   <= STREAM;
        end
        STREAM: begin
          shift_reg   <= shift_reg >> 1;
          bit_idx_reg <= bit_idx_reg + IDX_W'(1);
          cnt_reg     <= cnt_next;
          if (bit_idx_reg == LAST_IDX) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          cnt_reg      <= cnt_next;
          result_id    <= id_reg;
          result_count <= cnt_next;
          state_reg    <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Status and detector-side outputs are decoded from the state register.
  // They are forced quiet while reset is asserted, and the detector is held in clear.
  always_comb begin
    busy      = !rst && (state_reg != IDLE);
    done      = !rst && (state_reg == DONE);
    det_valid = !rst && (state_reg == STREAM);
    det_bit   = !rst && (state_reg == STREAM) && shift_reg[0];
    det_clr   = rst || (state_reg == CLEAR);
  end

endmodule
